// File: rtl/pkt_len_feed_pkg.sv
// Shared types and helpers for the GEM transmit length feed.
package gem_mm2s_pkg;

  localparam int LEN_WIDTH_DEF  = 11;
  localparam int SLOTS_LOG2_DEF = 2;

  // Bytes carried by one data-bus beat.
  function automatic int beat_bytes(input int bus_width);
    return bus_width / 8;
  endfunction

  typedef logic [LEN_WIDTH_DEF-1:0]  pkt_len_t;
  typedef logic [SLOTS_LOG2_DEF:0]   slot_ptr_t;

  typedef enum logic [0:0] {
    RD_IDLE,
    RD_READ
  } rd_state_t;

endpackage

// File: rtl/pkt_len_feed_if.sv
// Handshake bundle between the length feed and its ingress, PS and GEM-read neighbours.
interface pkt_len_feed_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int LEN_WIDTH  = 11
) ();

  logic                  i_last;
  logic                  i_last_valid;
  logic                  i_last_ready;
  logic [LEN_WIDTH-1:0]  o_len_data;
  logic                  o_len_valid;
  logic                  i_len_ready;
  logic                  o_tx_request;
  logic [ADDR_WIDTH-1:0] i_addr_data;
  logic                  i_addr_valid;
  logic                  i_addr_ready;
  logic                  i_tx_complete;
  logic                  o_beat_pop;
  logic                  o_beat_pad;
  logic                  o_beat_last;
  logic                  o_err;

  modport slave (
    input  i_last, i_last_valid, i_len_ready, i_addr_data, i_addr_valid, i_tx_complete,
    output i_last_ready, o_len_data, o_len_valid, o_tx_request, i_addr_ready,
           o_beat_pop, o_beat_pad, o_beat_last, o_err
  );

  modport master (
    output i_last, i_last_valid, i_len_ready, i_addr_data, i_addr_valid, i_tx_complete,
    input  i_last_ready, o_len_data, o_len_valid, o_tx_request, i_addr_ready,
           o_beat_pop, o_beat_pad, o_beat_last, o_err
  );

endinterface

// File: rtl/pkt_len_feed_ring.sv
// Packet length ring: slots are written at ingress, announced to the PS,
// consumed by the GEM read side and freed on TX completion.
module pkt_len_ring #(
  parameter int LEN_WIDTH  = 11,
  parameter int SLOTS_LOG2 = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 push,
  input  logic [LEN_WIDTH-1:0] push_len,
  input  logic                 ps_pop,
  input  logic                 rd_pop,
  input  logic                 free_pop,
  output logic                 full,
  output logic                 announced,
  output logic                 readable,
  output logic                 completable,
  output logic [LEN_WIDTH-1:0] ps_len,
  output logic [LEN_WIDTH-1:0] rd_len
);

  localparam int SLOTS = 1 << SLOTS_LOG2;
  localparam logic [SLOTS_LOG2:0] PTR_ONE   = 1;
  localparam logic [SLOTS_LOG2:0] PTR_SLOTS = (SLOTS_LOG2 + 1)'(SLOTS);

  logic [SLOTS_LOG2:0]  wr_q, wr_d;
  logic [SLOTS_LOG2:0]  ps_q, ps_d;
  logic [SLOTS_LOG2:0]  rd_q, rd_d;
  logic [SLOTS_LOG2:0]  free_q, free_d;
  logic [LEN_WIDTH-1:0] slot_q [SLOTS];
  logic [LEN_WIDTH-1:0] slot_d [SLOTS];

  assign full        = (wr_q - free_q) == PTR_SLOTS;
  assign announced   = ps_q != wr_q;
  assign readable    = rd_q != ps_q;
  assign completable = free_q != rd_q;
  assign ps_len      = slot_q[ps_q[SLOTS_LOG2-1:0]];
  assign rd_len      = slot_q[rd_q[SLOTS_LOG2-1:0]];

  // Advance each pointer on its own event and capture pushed lengths.
  always_comb begin
    wr_d   = wr_q;
    ps_d   = ps_q;
    rd_d   = rd_q;
    free_d = free_q;
    slot_d = slot_q;
    if (push) begin
      slot_d[wr_q[SLOTS_LOG2-1:0]] = push_len;
      wr_d = wr_q + PTR_ONE;
    end
    if (ps_pop)   ps_d   = ps_q + PTR_ONE;
    if (rd_pop)   rd_d   = rd_q + PTR_ONE;
    if (free_pop) free_d = free_q + PTR_ONE;
  end

  // Pointer and slot registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q   <= '0;
      ps_q   <= '0;
      rd_q   <= '0;
      free_q <= '0;
      for (int i = 0; i < SLOTS; i++) slot_q[i] <= '0;
    end else begin
      wr_q   <= wr_d;
      ps_q   <= ps_d;
      rd_q   <= rd_d;
      free_q <= free_d;
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/pkt_len_feed.sv
// Transmit length feed: counts ingress beats into packet lengths, hands them
// to the PS, and steers each GEM read beat to real data or zero padding.
module pkt_len_feed
  import gem_mm2s_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int BUS_WIDTH      = 32,
  parameter int BASE_ADDR      = 0,
  parameter int LEN_WIDTH      = 11,
  parameter int PKT_SLOTS_LOG2 = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  pkt_len_feed_if.slave  bus
);

  localparam int BEAT_BYTES = beat_bytes(BUS_WIDTH);
  localparam int BYTES_W    = LEN_WIDTH + $clog2(BEAT_BYTES) + 1;

  localparam logic [BYTES_W-1:0]    ONE_W     = 1;
  localparam logic [BYTES_W-1:0]    BB_W      = BYTES_W'(BEAT_BYTES);
  localparam logic [BYTES_W-1:0]    LEN_MAX_W = BYTES_W'((1 << LEN_WIDTH) - 1);
  localparam logic [LEN_WIDTH-1:0]  BB_LEN    = LEN_WIDTH'(BEAT_BYTES);
  localparam logic [LEN_WIDTH-1:0]  CNT_ONE   = 1;
  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);

  logic                 full, announced, readable, completable;
  logic [LEN_WIDTH-1:0] ps_len, rd_len;
  logic                 push, ps_pop, rd_pop, free_pop;
  logic [LEN_WIDTH-1:0] push_len;
  logic                 len_sat;

  logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [BYTES_W-1:0]   byte_cnt;
  logic                 tx_request_q, tx_request_d;

  rd_state_t            state_q, state_d;
  logic [LEN_WIDTH-1:0] remain_q, remain_d;
  logic [LEN_WIDTH-1:0] src;
  logic                 is_base, addr_ready, start, fsm_err;
  logic                 beat_pop_q, beat_pop_d;
  logic                 beat_pad_q, beat_pad_d;
  logic                 beat_last_q, beat_last_d;
  logic                 err_q, err_d;

  pkt_len_ring #(
    .LEN_WIDTH  (LEN_WIDTH),
    .SLOTS_LOG2 (PKT_SLOTS_LOG2)
  ) u_ring (
    .clk         (clk),
    .reset_n     (reset_n),
    .push        (push),
    .push_len    (push_len),
    .ps_pop      (ps_pop),
    .rd_pop      (rd_pop),
    .free_pop    (free_pop),
    .full        (full),
    .announced   (announced),
    .readable    (readable),
    .completable (completable),
    .ps_len      (ps_len),
    .rd_len      (rd_len)
  );

  assign byte_cnt = (BYTES_W'(beat_cnt_q) + ONE_W) * BB_W;
  assign ps_pop   = announced && bus.i_len_ready;
  assign free_pop = bus.i_tx_complete && completable;
  assign is_base  = bus.i_addr_data == BASE;

  assign bus.i_last_ready = !full;
  assign bus.o_len_valid  = announced;
  assign bus.o_len_data   = ps_len;
  assign bus.i_addr_ready = addr_ready;
  assign bus.o_tx_request = tx_request_q;
  assign bus.o_beat_pop   = beat_pop_q;
  assign bus.o_beat_pad   = beat_pad_q;
  assign bus.o_beat_last  = beat_last_q;
  assign bus.o_err        = err_q;

  // Ingress: count accepted beats and close a packet length on TLAST, saturating oversize packets.
  always_comb begin
    beat_cnt_d   = beat_cnt_q;
    push         = 1'b0;
    push_len     = byte_cnt[LEN_WIDTH-1:0];
    len_sat      = 1'b0;
    if (bus.i_last_valid && !full) begin
      if (bus.i_last) begin
        push       = 1'b1;
        beat_cnt_d = '0;
        if (byte_cnt > LEN_MAX_W) begin
          push_len = '1;
          len_sat  = 1'b1;
        end
      end else if (beat_cnt_q != '1) begin
        beat_cnt_d = beat_cnt_q + CNT_ONE;
      end
    end
    tx_request_d = push;
  end

  // Read FSM: a BASE beat opens the next announced packet; each accepted beat pops data until the length runs out, then pads.
  always_comb begin
    state_d     = state_q;
    remain_d    = remain_q;
    addr_ready  = 1'b0;
    rd_pop      = 1'b0;
    start       = 1'b0;
    fsm_err     = 1'b0;
    beat_pop_d  = 1'b0;
    beat_pad_d  = 1'b0;
    beat_last_d = 1'b0;
    case (state_q)
      RD_IDLE: begin
        addr_ready = is_base && readable;
        if (bus.i_addr_valid && !is_base) fsm_err = 1'b1;
      end
      RD_READ: begin
        if (is_base) begin
          addr_ready = readable;
          if (bus.i_addr_valid && remain_q != '0) fsm_err = 1'b1;
        end else begin
          addr_ready = 1'b1;
        end
      end
      default: state_d = RD_IDLE;
    endcase
    if (bus.i_addr_valid && addr_ready && is_base) begin
      start   = 1'b1;
      rd_pop  = 1'b1;
      state_d = RD_READ;
    end
    src = start ? rd_len : remain_q;
    if (bus.i_addr_valid && addr_ready) begin
      beat_pop_d  = src != '0;
      beat_pad_d  = src == '0;
      beat_last_d = (src != '0) && (src <= BB_LEN);
      remain_d    = (src > BB_LEN) ? (src - BB_LEN) : '0;
    end
  end

  // Sticky error collects length saturation, read protocol faults and spurious completions.
  always_comb begin
    err_d = err_q | len_sat | fsm_err | (bus.i_tx_complete && !completable);
  end

  // State, counter and registered output flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt_q   <= '0;
      tx_request_q <= 1'b0;
      state_q      <= RD_IDLE;
      remain_q     <= '0;
      beat_pop_q   <= 1'b0;
      beat_pad_q   <= 1'b0;
      beat_last_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      beat_cnt_q   <= beat_cnt_d;
      tx_request_q <= tx_request_d;
      state_q      <= state_d;
      remain_q     <= remain_d;
      beat_pop_q   <= beat_pop_d;
      beat_pad_q   <= beat_pad_d;
      beat_last_q  <= beat_last_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_pkt_len_feed.sv
// Directed bench for pkt_len_feed: ingress lengths, PS hand-off, read steering,
// ring full/complete interplay, protocol errors and asynchronous reset.
module tb_pkt_len_feed;
  import gem_mm2s_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pkt_len_feed_if #(.ADDR_WIDTH(12), .LEN_WIDTH(11)) bus ();

  pkt_len_feed #(
    .ADDR_WIDTH     (12),
    .BUS_WIDTH      (32),
    .BASE_ADDR      (0),
    .LEN_WIDTH      (11),
    .PKT_SLOTS_LOG2 (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance n clocks, landing just after the rising edge.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pushPacket(input int beats);
    for (int i = 0; i < beats; i++) begin
      bus.i_last_valid = 1'b1;
      bus.i_last       = (i == beats - 1);
      #1;
      begin
        int guard;
        guard = 0;
        while (!bus.i_last_ready && guard < 20) begin
          applyStimulus(1);
          guard++;
        end
        if (guard >= 20) checkOutput("push_timeout", 32'd0, 32'd1);
      end
      applyStimulus(1);
    end
    bus.i_last_valid = 1'b0;
    bus.i_last       = 1'b0;
    checkOutput("tx_request", bus.o_tx_request, 32'd1);
  endtask

  task automatic takeLen(input string tag, input int exp_len);
    checkOutput({tag, "_valid"}, bus.o_len_valid, 32'd1);
    checkOutput(tag, bus.o_len_data, exp_len);
    bus.i_len_ready = 1'b1;
    applyStimulus(1);
    bus.i_len_ready = 1'b0;
  endtask

  // exp is {pop, pad, last} expected one cycle after the handshake.
  task automatic readBeat(input string tag, input int addr, input logic [2:0] exp);
    bus.i_addr_valid = 1'b1;
    bus.i_addr_data  = 12'(addr);
    #1;
    checkOutput({tag, "_ready"}, bus.i_addr_ready, 32'd1);
    applyStimulus(1);
    bus.i_addr_valid = 1'b0;
    checkOutput(tag, {bus.o_beat_pop, bus.o_beat_pad, bus.o_beat_last}, exp);
  endtask

  task automatic completeTx();
    bus.i_tx_complete = 1'b1;
    applyStimulus(1);
    bus.i_tx_complete = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.i_last        = 1'b0;
    bus.i_last_valid  = 1'b0;
    bus.i_len_ready   = 1'b0;
    bus.i_addr_data   = '0;
    bus.i_addr_valid  = 1'b0;
    bus.i_tx_complete = 1'b0;
    reset_n           = 1'b0;
    applyStimulus(3);
    reset_n = 1'b1;
    applyStimulus(1);

    $display("[TB] reset state");
    checkOutput("rst_len_valid", bus.o_len_valid, 32'd0);
    checkOutput("rst_err", bus.o_err, 32'd0);
    checkOutput("rst_last_ready", bus.i_last_ready, 32'd1);
    checkOutput("rst_addr_ready", bus.i_addr_ready, 32'd0);
    checkOutput("rst_tx_request", bus.o_tx_request, 32'd0);
    checkOutput("rst_beats", {bus.o_beat_pop, bus.o_beat_pad, bus.o_beat_last}, 32'd0);

    $display("[TB] single 16-beat packet");
    pushPacket(16);
    applyStimulus(1);
    checkOutput("tx_request_pulse_end", bus.o_tx_request, 32'd0);
    takeLen("single_len", 64);
    for (int i = 0; i < 16; i++)
      readBeat("single_beat", i * 4, (i == 15) ? 3'b101 : 3'b100);
    applyStimulus(1);
    checkOutput("single_beats_idle", {bus.o_beat_pop, bus.o_beat_pad, bus.o_beat_last}, 32'd0);
    completeTx();
    checkOutput("single_err", bus.o_err, 32'd0);

    $display("[TB] padding after short packet");
    pushPacket(3);
    takeLen("pad_len", 12);
    for (int i = 0; i < 8; i++)
      readBeat("pad_beat", i * 4, (i < 2) ? 3'b100 : (i == 2) ? 3'b101 : 3'b010);
    completeTx();

    $display("[TB] full ring");
    for (int k = 0; k < 4; k++) pushPacket(1);
    checkOutput("full_last_ready", bus.i_last_ready, 32'd0);
    takeLen("full_len1", 4);
    readBeat("full_rd1", 0, 3'b101);
    bus.i_last_valid  = 1'b1;
    bus.i_last        = 1'b1;
    bus.i_tx_complete = 1'b1;
    #1;
    checkOutput("full_and_complete_ready", bus.i_last_ready, 32'd0);
    applyStimulus(1);
    bus.i_tx_complete = 1'b0;
    checkOutput("ready_after_complete", bus.i_last_ready, 32'd1);
    applyStimulus(1);
    bus.i_last_valid = 1'b0;
    bus.i_last       = 1'b0;
    checkOutput("fifth_tx_request", bus.o_tx_request, 32'd1);
    for (int k = 0; k < 4; k++) takeLen("full_len_rest", 4);
    for (int k = 0; k < 4; k++) readBeat("full_rd_rest", 0, 3'b101);
    for (int k = 0; k < 4; k++) completeTx();
    checkOutput("full_drained_ready", bus.i_last_ready, 32'd1);
    checkOutput("full_err", bus.o_err, 32'd0);

    $display("[TB] back-to-back reads");
    pushPacket(2);
    pushPacket(1);
    takeLen("b2b_len8", 8);
    takeLen("b2b_len4", 4);
    readBeat("b2b_base0", 0, 3'b100);
    readBeat("b2b_plus4", 4, 3'b101);
    readBeat("b2b_base1", 0, 3'b101);
    bus.i_addr_valid = 1'b1;
    bus.i_addr_data  = '0;
    #1;
    checkOutput("b2b_rd_advanced", bus.i_addr_ready, 32'd0);
    bus.i_addr_valid = 1'b0;
    applyStimulus(1);
    completeTx();
    completeTx();
    checkOutput("b2b_err", bus.o_err, 32'd0);

    $display("[TB] error cases");
    bus.i_addr_valid = 1'b1;
    bus.i_addr_data  = '0;
    #1;
    checkOutput("no_announce_ready", bus.i_addr_ready, 32'd0);
    bus.i_addr_valid = 1'b0;
    applyStimulus(1);
    completeTx();
    checkOutput("spurious_complete_err", bus.o_err, 32'd1);
    checkOutput("spurious_last_ready", bus.i_last_ready, 32'd1);
    checkOutput("spurious_len_valid", bus.o_len_valid, 32'd0);
    pushPacket(1);
    takeLen("after_err_len", 4);
    readBeat("after_err_rd", 0, 3'b101);
    completeTx();

    $display("[TB] mid-packet reset");
    pushPacket(4);
    takeLen("mid_len", 16);
    pushPacket(1);
    readBeat("mid_first", 0, 3'b100);
    bus.i_addr_valid = 1'b1;
    bus.i_addr_data  = 12'h004;
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_beats", {bus.o_beat_pop, bus.o_beat_pad, bus.o_beat_last}, 32'd0);
    checkOutput("mid_rst_len_valid", bus.o_len_valid, 32'd0);
    checkOutput("mid_rst_err", bus.o_err, 32'd0);
    checkOutput("mid_rst_last_ready", bus.i_last_ready, 32'd1);
    checkOutput("mid_rst_addr_ready", bus.i_addr_ready, 32'd0);
    bus.i_addr_valid = 1'b0;
    applyStimulus(2);
    reset_n = 1'b1;
    applyStimulus(1);

    $display("[TB] length saturation boundary");
    pushPacket(511);
    checkOutput("len_2044_err", bus.o_err, 32'd0);
    takeLen("len_2044", 2044);
    pushPacket(512);
    checkOutput("len_sat_err", bus.o_err, 32'd1);
    takeLen("len_sat", 2047);

    $display("[TB] non-base beat in idle");
    reset_n = 1'b0;
    applyStimulus(1);
    reset_n = 1'b1;
    applyStimulus(1);
    checkOutput("idle_err_clear", bus.o_err, 32'd0);
    bus.i_addr_valid = 1'b1;
    bus.i_addr_data  = 12'h004;
    #1;
    checkOutput("idle_nonbase_ready", bus.i_addr_ready, 32'd0);
    applyStimulus(1);
    bus.i_addr_valid = 1'b0;
    checkOutput("idle_nonbase_err", bus.o_err, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
